// File: rtl/uart_rx_buzzer_feeder_pkg.sv
// Shared definitions for the UART receiver that feeds the buzzer interface FIFO:
// FSM encoding, default bit period and 8N1 frame constants.
package uart_rx_buzzer_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    PUSH  = 3'd4,
    BREAK = 3'd5
  } rx_state_e;

  // 50 MHz system clock at 9600 baud.
  localparam int DEFAULT_BAUD_DIV = 5208;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

endpackage

// File: rtl/uart_rx_buzzer_feeder_sync.sv
// Multi-stage synchroniser for the asynchronous RX pin; resets to the idle-high
// line level so a reset never looks like a start bit.
module uart_rx_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_buzzer_feeder.sv
// 8N1 UART receiver that writes each good byte into the buzzer interface FIFO,
// flagging bytes dropped on a full FIFO or a bad stop bit.
module uart_rx_buzzer_feeder
  import uart_rx_buzzer_feeder_pkg::*;
#(
  parameter int BAUD_DIV    = DEFAULT_BAUD_DIV,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK,
  input  logic                 RSTn,
  input  logic                 RX_Pin_In,
  input  logic                 Full_Sig,
  output logic                 Write_Req_Sig,
  output logic [DATA_BITS-1:0] FIFO_Write_Data,
  output logic                 Overrun_Sig,
  output logic                 Frame_Err_Sig
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] HALF_LIMIT = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LIMIT = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state;
  rx_state_e            state_next;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shift_reg;

  logic baud_done;
  logic shift_en;
  logic load_data;
  logic set_overrun;
  logic set_frame_err;

  uart_rx_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RSTn),
    .rx   (RX_Pin_In),
    .rx_s (rx_s)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_next    = state;
    baud_done     = 1'b0;
    shift_en      = 1'b0;
    load_data     = 1'b0;
    set_overrun   = 1'b0;
    set_frame_err = 1'b0;

    case (state)
      IDLE: begin
        if (!rx_s) state_next = START;
      end
      // Half a bit in, so every later sample lands mid-bit; a high level here
      // means the falling edge was noise.
      START: begin
        baud_done = (baud_cnt == HALF_LIMIT);
        if (baud_done) state_next = rx_s ? IDLE : DATA;
      end
      DATA: begin
        baud_done = (baud_cnt == FULL_LIMIT);
        if (baud_done) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_next = STOP;
        end
      end
      STOP: begin
        baud_done = (baud_cnt == FULL_LIMIT);
        if (baud_done) begin
          if (rx_s == STOP_LEVEL) begin
            if (Full_Sig) begin
              set_overrun = 1'b1;
              state_next  = IDLE;
            end else begin
              load_data  = 1'b1;
              state_next = PUSH;
            end
          end else begin
            set_frame_err = 1'b1;
            state_next    = BREAK;
          end
        end
      end
      PUSH: begin
        state_next = IDLE;
      end
      // A line held low after a bad stop bit must not be re-read as frames.
      BREAK: begin
        if (rx_s == STOP_LEVEL) state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      baud_cnt        <= '0;
      bit_cnt         <= '0;
      shift_reg       <= '0;
      FIFO_Write_Data <= '0;
      Overrun_Sig     <= 1'b0;
      Frame_Err_Sig   <= 1'b0;
    end else begin
      Overrun_Sig   <= set_overrun;
      Frame_Err_Sig <= set_frame_err;

      // Counter only runs in the timed states and restarts on every entry.
      if (!(state inside {START, DATA, STOP}) || (state_next != state) || baud_done) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end

      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (shift_en) begin
        bit_cnt <= bit_cnt + BIT_W'(1);
      end

      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
      if (load_data) FIFO_Write_Data <= shift_reg;
    end
  end

  assign Write_Req_Sig = (state == PUSH);

endmodule

// File: tb/tb_uart_rx_buzzer_feeder.sv
// Scoreboard bench for the UART receiver: expected bytes are queued as frames
// are driven and checked against each FIFO write strobe.
module tb_uart_rx_buzzer_feeder;

  localparam int BAUD = 16;
  localparam int SYNC = 2;
  // Posedges from driving the start bit to the cycle in which the write strobe is
  // high: synchroniser, IDLE detect, half bit, 8 data bits, stop bit.
  localparam int LATENCY = SYNC + 1 + BAUD / 2 + 9 * BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       full;
  logic       write_req;
  logic [7:0] write_data;
  logic       overrun;
  logic       frame_err;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int wr_cnt = 0;
  int ovr_cnt = 0;
  int fe_cnt = 0;
  int last_wr_cyc = 0;
  int frame_start_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] last_byte = 8'h00;

  always #5 clk = ~clk;

  uart_rx_buzzer_feeder #(
    .BAUD_DIV   (BAUD),
    .SYNC_STAGES(SYNC)
  ) dut (
    .CLK            (clk),
    .RSTn           (rst_n),
    .RX_Pin_In      (rx),
    .Full_Sig       (full),
    .Write_Req_Sig  (write_req),
    .FIFO_Write_Data(write_data),
    .Overrun_Sig    (overrun),
    .Frame_Err_Sig  (frame_err)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on every write strobe.
  always @(negedge clk) begin
    if (write_req) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: got data=%02h with no byte expected", write_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (write_data !== e) begin
          bad++;
          $display("FAIL write_data: got %02h expected %02h", write_data, e);
        end
      end
    end
    if (overrun) ovr_cnt++;
    if (frame_err) fe_cnt++;
    if (write_req || overrun || frame_err) begin
      total++;
      if ($countones({write_req, overrun, frame_err}) !== 1) begin
        bad++;
        $display("FAIL strobe_exclusive: got wr=%b ovr=%b fe=%b expected one-hot",
                 write_req, overrun, frame_err);
      end
    end
  end

  // Call at a negedge; drives one 8N1 frame, LSB first.
  task automatic send_frame(input logic [7:0] b, input logic stop_lvl, input bit expect_write);
    if (expect_write) begin
      exp_q.push_back(b);
      last_byte = b;
    end
    frame_start_cyc = cyc;
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = stop_lvl;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 4 * BAUD && exp_q.size() != 0; i++) @(negedge clk);
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL %s_drain: got %0d bytes pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_deltas(input string name, input int w0, input int o0, input int f0,
                              input int w_exp, input int o_exp, input int f_exp);
    total++;
    if ((wr_cnt - w0) !== w_exp) begin
      bad++;
      $display("FAIL %s_writes: got %0d expected %0d", name, wr_cnt - w0, w_exp);
    end
    total++;
    if ((ovr_cnt - o0) !== o_exp) begin
      bad++;
      $display("FAIL %s_overruns: got %0d expected %0d", name, ovr_cnt - o0, o_exp);
    end
    total++;
    if ((fe_cnt - f0) !== f_exp) begin
      bad++;
      $display("FAIL %s_frame_errs: got %0d expected %0d", name, fe_cnt - f0, f_exp);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    total++;
    if (write_req !== 1'b0) begin
      bad++;
      $display("FAIL %s_write_req: got %b expected 0", name, write_req);
    end
    total++;
    if (write_data !== 8'h00) begin
      bad++;
      $display("FAIL %s_write_data: got %02h expected 00", name, write_data);
    end
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL %s_overrun: got %b expected 0", name, overrun);
    end
    total++;
    if (frame_err !== 1'b0) begin
      bad++;
      $display("FAIL %s_frame_err: got %b expected 0", name, frame_err);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    full  = 1'b0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic test_single_byte();
    int w0 = wr_cnt, o0 = ovr_cnt, f0 = fe_cnt;
    int start_cyc;
    send_frame(8'hA5, 1'b1, 1'b1);
    start_cyc = frame_start_cyc;
    wait_drain("single");
    check_deltas("single", w0, o0, f0, 1, 0, 0);
    total++;
    if ((last_wr_cyc - start_cyc) !== LATENCY) begin
      bad++;
      $display("FAIL single_latency: got %0d expected %0d", last_wr_cyc - start_cyc, LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = wr_cnt, o0 = ovr_cnt, f0 = fe_cnt;
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    wait_drain("b2b");
    check_deltas("b2b", w0, o0, f0, 2, 0, 0);
  endtask

  task automatic test_glitch();
    int w0 = wr_cnt, o0 = ovr_cnt, f0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BAUD) @(negedge clk);
    check_deltas("glitch", w0, o0, f0, 0, 0, 0);
    w0 = wr_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    wait_drain("glitch_after");
    check_deltas("glitch_after", w0, o0, f0, 1, 0, 0);
  endtask

  task automatic test_frame_error();
    int w0 = wr_cnt, o0 = ovr_cnt, f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check_deltas("frame_err", w0, o0, f0, 0, 0, 1);
    rx = 1'b1;
    repeat (BAUD) @(negedge clk);
    send_frame(8'h11, 1'b1, 1'b1);
    wait_drain("frame_err_after");
    check_deltas("frame_err_after", w0, o0, f0, 1, 0, 1);
  endtask

  task automatic test_overrun();
    int w0 = wr_cnt, o0 = ovr_cnt, f0 = fe_cnt;
    full = 1'b1;
    send_frame(8'h55, 1'b1, 1'b0);
    full = 1'b0;
    repeat (BAUD) @(negedge clk);
    check_deltas("overrun", w0, o0, f0, 0, 1, 0);
    total++;
    if (write_data !== last_byte) begin
      bad++;
      $display("FAIL overrun_hold: got %02h expected %02h", write_data, last_byte);
    end
  endtask

  task automatic test_reset_mid_frame();
    int w0, o0, f0;
    logic [7:0] b;
    b = 8'hC3;
    rx = 1'b0;
    repeat (BAUD) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      repeat (BAUD) @(negedge clk);
    end
    rx = b[4];
    repeat (BAUD / 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    rx    = 1'b1;
    last_byte = 8'h00;
    w0 = wr_cnt; o0 = ovr_cnt; f0 = fe_cnt;
    repeat (12 * BAUD) @(negedge clk);
    check_deltas("mid_reset_quiet", w0, o0, f0, 0, 0, 0);
    send_frame(8'h81, 1'b1, 1'b1);
    wait_drain("mid_reset_after");
    check_deltas("mid_reset_after", w0, o0, f0, 1, 0, 0);
    total++;
    if (write_data !== 8'h81) begin
      bad++;
      $display("FAIL mid_reset_hold: got %02h expected 81", write_data);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
